// File: rtl/sram_like_to_axi_pkg.sv
// Shared definitions for the SRAM-like to AXI3 bridge: state and owner encodings,
// fixed AXI field values, ID constants and the write-strobe encoder.
package sram_like_to_axi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_ADDR,
    ST_RD_DATA,
    ST_WR_ADDR,
    ST_WR_RESP
  } state_e;

  typedef enum logic {
    OWN_INST = 1'b0,
    OWN_DATA = 1'b1
  } owner_e;

  localparam logic [3:0] AXI_LEN_SINGLE = 4'd0;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [3:0] ID_INST        = 4'd0;
  localparam logic [3:0] ID_DATA        = 4'd1;

  // size 3 is illegal on the SRAM-like side; treat it as a full word
  function automatic logic [3:0] calc_wstrb(input logic [1:0] size, input logic [1:0] offset);
    case (size)
      2'd0:    return 4'b0001 << offset;
      2'd1:    return 4'b0011 << offset;
      default: return 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/sram_like_to_axi_if.sv
// AXI3 single-port bus between the bridge (master) and the downstream slave.
interface sram_like_to_axi_if;

  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [3:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [1:0]  arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;

  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [3:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic [1:0]  awlock;
  logic [3:0]  awcache;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;

  logic [3:0]  wid;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;

  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready,
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    input  awready,
    output wid, wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready,
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    output awready,
    input  wid, wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready
  );

endinterface

// File: rtl/sram_like_arbiter.sv
// Grants one SRAM-like master per idle cycle (data has priority as the older
// pipeline stage) and latches the accepted request for the AXI channel FSM.
module sram_like_arbiter
  import sram_like_to_axi_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        idle,
  input  logic        inst_req,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        inst_addr_ok,
  output logic        data_addr_ok,
  output logic        accept,
  output logic        accept_wr,
  output owner_e      owner_q,
  output logic [1:0]  size_q,
  output logic [31:0] addr_q,
  output logic [31:0] wdata_q,
  output logic [3:0]  wstrb_q
);

  assign data_addr_ok = idle & ~rst & data_req;
  assign inst_addr_ok = idle & ~rst & inst_req & ~data_req;
  assign accept       = data_addr_ok | inst_addr_ok;
  assign accept_wr    = data_addr_ok & data_wr;

  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q <= OWN_INST;
      size_q  <= 2'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      wstrb_q <= 4'd0;
    end else if (data_addr_ok) begin
      owner_q <= OWN_DATA;
      size_q  <= data_size;
      addr_q  <= data_addr;
      wdata_q <= data_wdata;
      wstrb_q <= calc_wstrb(data_size, data_addr[1:0]);
    end else if (inst_addr_ok) begin
      owner_q <= OWN_INST;
      size_q  <= inst_size;
      addr_q  <= inst_addr;
      wdata_q <= 32'd0;
      wstrb_q <= calc_wstrb(inst_size, inst_addr[1:0]);
    end
  end

endmodule

// File: rtl/sram_like_to_axi.sv
// Bridges the instruction and data SRAM-like masters onto one AXI3 port with a
// single outstanding transaction and one-cycle data_ok completion pulses.
module sram_like_to_axi
  import sram_like_to_axi_pkg::*;
#(
  parameter logic [3:0] ARID_INST = ID_INST,
  parameter logic [3:0] ARID_DATA = ID_DATA,
  parameter logic [3:0] AWID_DATA = ID_DATA
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  sram_like_to_axi_if.master axi
);

  state_e      state_q, state_d;
  logic        aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic        accept, accept_wr;
  owner_e      owner_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic [3:0]  wstrb_q;
  logic        arvalid, rready, awvalid, wvalid, bready;
  logic        unused_ok;

  sram_like_arbiter u_arbiter (
    .clk          (clk),
    .rst          (rst),
    .idle         (state_q == ST_IDLE),
    .inst_req     (inst_req),
    .inst_size    (inst_size),
    .inst_addr    (inst_addr),
    .data_req     (data_req),
    .data_wr      (data_wr),
    .data_size    (data_size),
    .data_addr    (data_addr),
    .data_wdata   (data_wdata),
    .inst_addr_ok (inst_addr_ok),
    .data_addr_ok (data_addr_ok),
    .accept       (accept),
    .accept_wr    (accept_wr),
    .owner_q      (owner_q),
    .size_q       (size_q),
    .addr_q       (addr_q),
    .wdata_q      (wdata_q),
    .wstrb_q      (wstrb_q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      rdata_q   <= 32'd0;
    end else begin
      state_q   <= state_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      if (state_q == ST_RD_DATA && axi.rvalid) rdata_q <= axi.rdata;
    end
  end

  always_comb begin
    state_d      = state_q;
    aw_done_d    = aw_done_q;
    w_done_d     = w_done_q;
    arvalid      = 1'b0;
    rready       = 1'b0;
    awvalid      = 1'b0;
    wvalid       = 1'b0;
    bready       = 1'b0;
    inst_data_ok = 1'b0;
    data_data_ok = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) state_d = accept_wr ? ST_WR_ADDR : ST_RD_ADDR;
      end
      ST_RD_ADDR: begin
        arvalid = 1'b1;
        if (axi.arready) state_d = ST_RD_DATA;
      end
      ST_RD_DATA: begin
        rready = 1'b1;
        if (axi.rvalid) begin
          if (owner_q == OWN_DATA) data_data_ok = 1'b1;
          else                     inst_data_ok = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_WR_ADDR: begin
        // AW and W complete independently; each valid drops after its own handshake
        awvalid = ~aw_done_q;
        wvalid  = ~w_done_q;
        if (awvalid && axi.awready) aw_done_d = 1'b1;
        if (wvalid && axi.wready)   w_done_d  = 1'b1;
        if (aw_done_d && w_done_d) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = ST_WR_RESP;
        end
      end
      ST_WR_RESP: begin
        bready = 1'b1;
        if (axi.bvalid) begin
          data_data_ok = 1'b1;
          state_d      = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign inst_rdata = inst_data_ok ? axi.rdata : rdata_q;
  assign data_rdata = data_data_ok ? axi.rdata : rdata_q;

  assign axi.arid    = (owner_q == OWN_DATA) ? ARID_DATA : ARID_INST;
  assign axi.araddr  = addr_q;
  assign axi.arlen   = AXI_LEN_SINGLE;
  assign axi.arsize  = {1'b0, size_q};
  assign axi.arburst = AXI_BURST_INCR;
  assign axi.arlock  = 2'd0;
  assign axi.arcache = 4'd0;
  assign axi.arprot  = 3'd0;
  assign axi.arvalid = arvalid;
  assign axi.rready  = rready;

  assign axi.awid    = AWID_DATA;
  assign axi.awaddr  = addr_q;
  assign axi.awlen   = AXI_LEN_SINGLE;
  assign axi.awsize  = {1'b0, size_q};
  assign axi.awburst = AXI_BURST_INCR;
  assign axi.awlock  = 2'd0;
  assign axi.awcache = 4'd0;
  assign axi.awprot  = 3'd0;
  assign axi.awvalid = awvalid;

  assign axi.wid    = AWID_DATA;
  assign axi.wdata  = wdata_q;
  assign axi.wstrb  = wstrb_q;
  assign axi.wlast  = 1'b1;
  assign axi.wvalid = wvalid;
  assign axi.bready = bready;

  // response IDs and error codes are deliberately ignored
  assign unused_ok = ^{inst_wr, inst_wdata, axi.rid, axi.rresp, axi.rlast, axi.bid, axi.bresp};

endmodule

// File: doc/sram_like_to_axi.md
Name: sram_like_to_axi

Overview:
Downstream of the instruction and data SRAM-like converters. Arbitrates the two SRAM-like masters onto one AXI3 master port. Allows one outstanding transaction at a time. Returns completion to the owning master as a single-cycle data_ok pulse.

Parameters:
ARID_INST, 4'd0, arid driven for instruction reads
ARID_DATA, 4'd1, arid driven for data reads
AWID_DATA, 4'd1, awid and wid driven for data writes

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
inst_req/inst_wr  in  1/1  instruction request; inst_wr is ignored and the request is always treated as a read
inst_size/inst_addr/inst_wdata  in  2/32/32  inst_wdata is unused
inst_addr_ok/inst_data_ok  out  1/1  accept / complete pulses
inst_rdata  out  32  read data
data_req/data_wr  in  1/1  data request, write flag
data_size/data_addr/data_wdata  in  2/32/32
data_addr_ok/data_data_ok  out  1/1
data_rdata  out  32
arid/araddr/arlen/arsize/arburst  out  4/32/4/3/2  AR channel
arlock/arcache/arprot  out  2/4/3  tied 0
arvalid/arready  out/in  1/1
rid/rdata/rresp/rlast  in  4/32/2/1
rvalid/rready  in/out  1/1
awid/awaddr/awlen/awsize/awburst  out  4/32/4/3/2  AW channel
awlock/awcache/awprot  out  2/4/3  tied 0
awvalid/awready  out/in  1/1
wid/wdata/wstrb/wlast  out  4/32/4/1
wvalid/wready  out/in  1/1
bid/bresp  in  4/2  ignored
bvalid/bready  in/out  1/1

Behaviour:
- Reset:
  - FSM goes to IDLE.
  - All valid/ready outputs and all addr_ok/data_ok outputs are 0.
  - Latched addr/size/wdata/owner registers are 0.
- Constant fields: arlen = awlen = 0, arburst = awburst = 2'b01, wlast = 1. arsize/awsize = {1'b0, latched size}.
- FSM states: IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_RESP.
- IDLE:
  - If data_req=1, data wins (data is the older pipeline stage). data_addr_ok=1 combinationally in this cycle.
  - Otherwise, if inst_req=1, inst_addr_ok=1.
  - At most one addr_ok is high per cycle, and only in IDLE.
  - On accept: latch addr, size, wdata and owner. Compute and latch wstrb.
  - Next state is WR_ADDR for a data write, else RD_ADDR.
- RD_ADDR: arvalid=1 with latched address and owner id. On arvalid&arready, go to RD_DATA.
- RD_DATA:
  - rready=1.
  - On rvalid&rready, pulse the owner's data_ok for exactly that cycle; the owner's rdata = AXI rdata in that cycle.
  - Then go to IDLE. The next accept happens no earlier than the following cycle.
- WR_ADDR:
  - awvalid and wvalid both rise on entry.
  - Each drops independently after its own handshake; track with aw_done/w_done flags.
  - Both handshakes may complete in the same cycle or in either order.
  - When both are complete, go to WR_RESP.
- WR_RESP: bready=1. On bvalid, pulse data_data_ok for one cycle, then go to IDLE.
- wstrb encoding, from latched size and addr[1:0]:
  - size 0: 4'b0001 << addr[1:0]
  - size 1: 4'b0011 << addr[1:0]
  - size 2: 4'b1111
  - size 3: illegal, drive 4'b1111
- data_rdata/inst_rdata: drive rdata to the owner during its data_ok pulse. Value is don't-care otherwise; a registered copy is held.
- No back-pressure on data_ok; the masters must accept the pulse.
- rresp/bresp errors are ignored.
- rid is not checked, because only one transaction is ever outstanding.
- Valid signals never drop before their handshake. An address or data change while valid is high is forbidden.
- Reset asserted mid-transaction aborts immediately. The AXI slave must also be reset.

Decomposition:
- Shared package: FSM state encodings, burst/len constants, ID constants, wstrb encoding function.
- One natural sub-module: sram_like_arbiter (IDLE grant, owner latch, addr_ok generation). The AXI channel FSM stays in the top module.

Test Plan:
- Inst read only: inst_req, addr 0xBFC00000; arready after 2 cycles, rvalid with 0x3C080000 after 3 more -> inst_addr_ok 1 cycle; arid=0, araddr=0xBFC00000, arsize=2; inst_data_ok single pulse with inst_rdata=0x3C080000.
- Simultaneous requests: inst_req and data_req (read, 0x80000010) in the same cycle -> data_addr_ok first, arid=1; inst_addr_ok only in the cycle after data_data_ok.
- Byte write: data_wr=1, size 0, addr 0x80000003, wdata 0x000000AB -> wstrb=4'b1000, awsize=0; data_data_ok only after bvalid.
- AW/W skew: awready 3 cycles after wready, and the reverse -> one handshake each, no re-assert; WR_RESP entered only after both.
- Halfword write at addr[1:0]=2 -> wstrb=4'b1100. Reset asserted in RD_DATA -> next cycle all valid/ready/ok outputs are 0 and the FSM is in IDLE.
